// File: rtl/memory.sv
// Word-organised, byte-addressed data RAM: synchronous write, combinational read,
// whole array cleared by async reset. Define MEMORY_BOUNDS_CHECK_EN to add range checking and the oob port.
module memory #(
  parameter int unsigned WORDS      = 1024,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  mem_write,
  output logic [DATA_WIDTH-1:0] data_out
`ifdef MEMORY_BOUNDS_CHECK_EN
  ,
  output logic                  oob
`endif
);

  localparam int unsigned BYTE_BITS = $clog2(DATA_WIDTH / 8);
  localparam int unsigned IDX_W     = $clog2(WORDS);

  logic [DATA_WIDTH-1:0] word_idx_s;
  logic [IDX_W-1:0]      idx_s;
  logic                  in_range_s;
  logic [DATA_WIDTH-1:0] mem_q [WORDS];

  assign word_idx_s = addr >> BYTE_BITS;
  assign idx_s      = word_idx_s[IDX_W-1:0];

`ifdef MEMORY_BOUNDS_CHECK_EN
  assign in_range_s = (word_idx_s < DATA_WIDTH'(WORDS));
  assign oob        = ~in_range_s;
`else
  // Upper index bits are deliberately discarded so the array wraps modulo WORDS.
  logic unused_idx_s;
  assign unused_idx_s = ^word_idx_s;
  assign in_range_s   = 1'b1;
`endif

  // Array storage: async clear of every word, single-word write on the rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(WORDS); i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_write && in_range_s) begin
      mem_q[idx_s] <= data_in;
    end
  end

  // Zero-latency read; an out-of-range word reads as zero.
  always_comb begin
    data_out = '0;
    if (in_range_s) begin
      data_out = mem_q[idx_s];
    end else begin
      data_out = '0;
    end
  end

endmodule

// File: tb/tb_memory.sv
// Randomised self-checking bench for memory against an associative-array model of the RAM.
// Builds with or without MEMORY_BOUNDS_CHECK_EN.
module tb_memory;

  localparam int unsigned WORDS = 1024;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic        mem_write;
  logic [31:0] data_out;
`ifdef MEMORY_BOUNDS_CHECK_EN
  logic        oob;
`endif

  int n_tests;
  int n_fail;

  logic [31:0] model_q [int unsigned];

  memory #(.WORDS(WORDS), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .data_in   (data_in),
    .mem_write (mem_write),
    .data_out  (data_out)
`ifdef MEMORY_BOUNDS_CHECK_EN
    ,
    .oob       (oob)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit model_in_range(input logic [31:0] a);
`ifdef MEMORY_BOUNDS_CHECK_EN
    return (a >> 2) < WORDS;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int unsigned idx;
    if (!model_in_range(a)) return 32'h0000_0000;
    idx = (a >> 2) % WORDS;
    if (model_q.exists(idx)) return model_q[idx];
    return 32'h0000_0000;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    if (model_in_range(a)) model_q[(a >> 2) % WORDS] = d;
  endtask

  // Write with read of the same address observed before and after the edge.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr      = a;
    data_in   = d;
    mem_write = 1'b1;
    #1;
    check_eq("wr_pre_old", data_out, model_read(a));
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    model_write(a, d);
    check_eq("wr_post_new", data_out, model_read(a));
  endtask

  task automatic do_read(input string tag, input logic [31:0] a);
    @(negedge clk);
    addr = a;
    #1;
    check_eq(tag, data_out, model_read(a));
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b1;
    addr      = 32'h0000_0000;
    data_in   = 32'h0000_0000;
    mem_write = 1'b0;

    // Reset held for two clocks, writes attempted meanwhile must be blocked.
    #2 rst_n = 1'b0;
    mem_write = 1'b1;
    data_in   = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_hold", data_out, 32'h0000_0000);
    @(negedge clk);
    mem_write = 1'b0;
    rst_n     = 1'b1;
    do_read("rst_rd_10", 32'h0000_0010);
    do_read("rst_rd_00", 32'h0000_0000);
    do_read("rst_rd_08", 32'h0000_0008);

    // Basic write then readback on the following negedge.
    do_write(32'h0000_0040, 32'hDEAD_BEEF);
    do_read("rd_40", 32'h0000_0040);
    check_eq("rd_40_const", data_out, 32'hDEAD_BEEF);

    // Random writes within a small window so addresses collide.
    for (int i = 0; i < 100; i++) begin
      do_write($urandom & 32'h0000_00F8, $urandom);
      do_read("rnd_rd", $urandom & 32'h0000_00F8);
    end
    for (int a = 0; a < 256; a += 8) begin
      do_read("rnd_sweep", 32'(a));
    end

    // Full-width random addresses exercise index wrap / bounds handling.
    for (int i = 0; i < 40; i++) begin
      do_write($urandom, $urandom);
      do_read("wide_rd", $urandom & 32'h0000_0FFF);
    end

    // Byte offset bits are ignored.
    do_write(32'h0000_0044, 32'h1234_5678);
    do_read("align_45", 32'h0000_0045);
    check_eq("align_45_c", data_out, 32'h1234_5678);
    do_read("align_46", 32'h0000_0046);
    check_eq("align_46_c", data_out, 32'h1234_5678);
    do_read("align_47", 32'h0000_0047);
    check_eq("align_47_c", data_out, 32'h1234_5678);

    // Async reset pulse between edges, with a blocked write underneath it.
    @(negedge clk);
    addr = 32'h0000_0044;
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_immediate", data_out, 32'h0000_0000);
    model_q.delete();
    mem_write = 1'b1;
    data_in   = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    check_eq("arst_wr_blocked", data_out, 32'h0000_0000);
    @(negedge clk);
    mem_write = 1'b0;
    rst_n     = 1'b1;
    do_read("arst_rd_44", 32'h0000_0044);
    do_read("arst_rd_40", 32'h0000_0040);
    for (int a = 0; a < 256; a += 8) begin
      do_read("arst_sweep", 32'(a));
    end
    do_write(32'h0000_0044, 32'h0BAD_CAFE);
    do_read("post_rst_wr", 32'h0000_0044);

    // Range: index 1024 wraps to 0 without checking, is dropped with checking.
    do_write(32'h0000_0000, 32'h1111_1111);
    do_write(32'h0000_1000, 32'hA5A5_A5A5);
    do_read("range_rd_0", 32'h0000_0000);
`ifdef MEMORY_BOUNDS_CHECK_EN
    check_eq("range_0_kept", data_out, 32'h1111_1111);
    check_eq("oob_lo", {31'd0, oob}, 32'h0000_0000);
    do_read("range_rd_1000", 32'h0000_1000);
    check_eq("range_1000_zero", data_out, 32'h0000_0000);
    check_eq("oob_hi", {31'd0, oob}, 32'h0000_0001);
    do_read("range_rd_ffc", 32'h0000_0FFC);
    check_eq("oob_last", {31'd0, oob}, 32'h0000_0000);
`else
    check_eq("range_0_wrap", data_out, 32'hA5A5_A5A5);
    do_read("range_rd_1000", 32'h0000_1000);
    check_eq("range_1000_wrap", data_out, 32'hA5A5_A5A5);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
